prog_loader: RTL

- Writable program memory for the TD4 board; a drop-in replacement for the fixed ROM on the CPU fetch bus.
- The CPU reads instructions combinationally, as before: 4-bit `address` in, 8-bit `data` out.
- A byte-stream load port (valid/ready) writes a 16-instruction program sequentially.
- While a load is in progress, `cpu_hold` is high and keeps the CPU in reset.

---
 rtl/td4_pkg.sv | 15 +
 rtl/prog_mem.sv | 32 +++
 rtl/prog_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// Shared TD4 constants and the program-loader state encoding.
package td4_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CHECK   = 3'd2,
      ERROR   = 3'd3,
      RELEASE = 3'd4
   } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program register file: asynchronous clear, one synchronous write port,
// one combinational read port.
module prog_mem #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage array; reset wipes every word so a half-loaded program never survives.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Writable TD4 program memory with a valid/ready byte loader that holds the CPU in reset.
// Optional checksum byte and ERROR state are enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = td4_pkg::ADDR_W,
   parameter int DATA_W         = td4_pkg::DATA_W,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   import td4_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [3:0]        REL_LAST = 4'(RELEASE_CYCLES - 1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              mem_we_s;
   logic              xfer_s;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] sum_total_s;
`endif

   assign load_ready = (state_q == LOAD) || (state_q == CHECK);
   assign cpu_hold   = (state_q != IDLE);
   assign load_done  = done_q;
   assign xfer_s     = load_valid && load_ready;
`ifdef PROG_LOADER_CHECKSUM_EN
   assign load_error  = (state_q == ERROR);
   assign sum_total_s = sum_q + load_data;
`else
   assign load_error = 1'b0;
`endif

   prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk_i   (clock),
      .rst_n_i (reset),
      .we_i    (mem_we_s),
      .waddr_i (ptr_q),
      .wdata_i (load_data),
      .raddr_i (address),
      .rdata_o (data)
   );

   // Loader state, pointer, release counter, done pulse and running sum.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   // Next-state logic; the pointer parks on the last word instead of wrapping.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      mem_we_s = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
               ptr_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (xfer_s) begin
               mem_we_s = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d    = sum_total_s;
`endif
               if (ptr_q == LAST_PTR) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = RELEASE;
`endif
                  cnt_d = 4'd0;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end else begin
               state_d = LOAD;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer_s) begin
               sum_d = sum_total_s;
               cnt_d = 4'd0;
               if (sum_total_s == '0) begin
                  state_d = RELEASE;
               end else begin
                  state_d = ERROR;
               end
            end else begin
               state_d = CHECK;
            end
         end
         ERROR: begin
            if (load_start) begin
               state_d = LOAD;
               ptr_d   = '0;
               sum_d   = '0;
            end else begin
               state_d = ERROR;
            end
         end
`else
         CHECK: begin
            state_d = IDLE;
         end
         ERROR: begin
            state_d = IDLE;
         end
`endif
         RELEASE: begin
            if (cnt_q == REL_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
